// File: rtl/ex_mem_reg_pkg.sv
// ex_mem_reg_pkg: shared constants for the EX->MEM boundary register
package ex_mem_reg_pkg;
  localparam logic [0:0] EXC_IDLE = 1'b0;
  localparam logic [0:0] EXC_PEND = 1'b1;
  localparam logic [31:0] ZeroWord = 32'h0;
  localparam logic [4:0] NOPRegAddr = 5'h0;
endpackage

// File: rtl/ex_mem_reg_sat_counter.sv
// ex_mem_reg_sat_counter: saturating event counter with synchronous clear
module ex_mem_reg_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = clear ? '0 : (inc && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign count = cnt_q;
endmodule

// File: rtl/ex_mem_reg.sv
// ex_mem_reg: EX->MEM pipeline register with overflow exception record and counter
module ex_mem_reg
  import ex_mem_reg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ex_wd_i,
  input  logic              ex_wreg_i,
  input  logic [DATA_W-1:0] ex_wdata_i,
  input  logic              ex_ov_i,
  input  logic [DATA_W-1:0] ex_pc_i,
  input  logic              stall_ex_i,
  input  logic              stall_mem_i,
  input  logic              flush_i,
  input  logic              exc_ack_i,
  output logic [ADDR_W-1:0] mem_wd_o,
  output logic              mem_wreg_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              exc_valid_o,
  output logic [DATA_W-1:0] exc_epc_o,
  output logic [ADDR_W-1:0] exc_wd_o,
  output logic              exc_lost_o,
  output logic [CNT_W-1:0]  ov_count_o
);
  logic [ADDR_W-1:0] mem_wd_q, mem_wd_d, exc_wd_q, exc_wd_d;
  logic              mem_wreg_q, mem_wreg_d, exc_lost_q, exc_lost_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d, exc_epc_q, exc_epc_d;
  logic [0:0]        exc_state_q, exc_state_d;
  logic              cap, bubble, load;
  always_comb begin
    cap         = ex_ov_i & ~flush_i & ~stall_ex_i;
    bubble      = flush_i | (stall_ex_i & ~stall_mem_i);
    mem_wd_d    = bubble ? NOPRegAddr : stall_mem_i ? mem_wd_q : ex_wd_i;
    mem_wreg_d  = bubble ? 1'b0 : stall_mem_i ? mem_wreg_q : ex_wreg_i;
    mem_wdata_d = bubble ? ZeroWord : stall_mem_i ? mem_wdata_q : ex_wdata_i;
    exc_state_d = cap ? EXC_PEND : exc_ack_i ? EXC_IDLE : exc_state_q;
    // an ack frees the slot in the same cycle, so a simultaneous capture replaces the record
    load        = cap & ((exc_state_q == EXC_IDLE) | exc_ack_i);
    exc_epc_d   = load ? ex_pc_i : exc_epc_q;
    exc_wd_d    = load ? ex_wd_i : exc_wd_q;
    exc_lost_d  = exc_lost_q | (cap & (exc_state_q == EXC_PEND) & ~exc_ack_i);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_wd_q    <= '0;
      mem_wreg_q  <= 1'b0;
      mem_wdata_q <= '0;
      exc_state_q <= EXC_IDLE;
      exc_epc_q   <= '0;
      exc_wd_q    <= '0;
      exc_lost_q  <= 1'b0;
    end else begin
      mem_wd_q    <= mem_wd_d;
      mem_wreg_q  <= mem_wreg_d;
      mem_wdata_q <= mem_wdata_d;
      exc_state_q <= exc_state_d;
      exc_epc_q   <= exc_epc_d;
      exc_wd_q    <= exc_wd_d;
      exc_lost_q  <= exc_lost_d;
    end
  end
  ex_mem_reg_sat_counter #(.W(CNT_W)) u_ov_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (cap),
    .clear(1'b0),
    .count(ov_count_o)
  );
  assign mem_wd_o    = mem_wd_q;
  assign mem_wreg_o  = mem_wreg_q;
  assign mem_wdata_o = mem_wdata_q;
  assign exc_valid_o = (exc_state_q == EXC_PEND);
  assign exc_epc_o   = exc_epc_q;
  assign exc_wd_o    = exc_wd_q;
  assign exc_lost_o  = exc_lost_q;
endmodule

// File: tb/tb_ex_mem_reg.sv
// tb_ex_mem_reg: directed vectors with a queued scoreboard and decoupled monitor
module tb_ex_mem_reg;
  typedef struct {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        vld;
    logic [31:0] epc;
    logic [4:0]  ewd;
    logic        lost;
    logic [1:0]  cnt;
  } exp_t;
  logic        clk = 1'b0, rst = 1'b0;
  logic [4:0]  ex_wd = '0;
  logic        ex_wreg = 1'b0, ex_ov = 1'b0, stall_ex = 1'b0, stall_mem = 1'b0, flush = 1'b0, ack = 1'b0;
  logic [31:0] ex_wdata = '0, ex_pc = '0;
  logic [4:0]  mem_wd, exc_wd;
  logic        mem_wreg, exc_valid, exc_lost;
  logic [31:0] mem_wdata, exc_epc;
  logic [1:0]  ov_count;
  exp_t        q[$];
  int          checks = 0, passes = 0, vec = 0;
  ex_mem_reg #(.DATA_W(32), .ADDR_W(5), .CNT_W(2)) dut (
    .clk(clk), .rst(rst),
    .ex_wd_i(ex_wd), .ex_wreg_i(ex_wreg), .ex_wdata_i(ex_wdata), .ex_ov_i(ex_ov), .ex_pc_i(ex_pc),
    .stall_ex_i(stall_ex), .stall_mem_i(stall_mem), .flush_i(flush), .exc_ack_i(ack),
    .mem_wd_o(mem_wd), .mem_wreg_o(mem_wreg), .mem_wdata_o(mem_wdata),
    .exc_valid_o(exc_valid), .exc_epc_o(exc_epc), .exc_wd_o(exc_wd),
    .exc_lost_o(exc_lost), .ov_count_o(ov_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL vec%0d %s: got %h expected %h", vec, name, act, exp);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or negedge rst);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("mem_wd", 32'(mem_wd), 32'(e.wd));
        chk("mem_wreg", 32'(mem_wreg), 32'(e.wreg));
        chk("mem_wdata", mem_wdata, e.wdata);
        chk("exc_valid", 32'(exc_valid), 32'(e.vld));
        chk("exc_epc", exc_epc, e.epc);
        chk("exc_wd", 32'(exc_wd), 32'(e.ewd));
        chk("exc_lost", 32'(exc_lost), 32'(e.lost));
        chk("ov_count", 32'(ov_count), 32'(e.cnt));
        vec++;
      end
    end
  end
  task automatic v(input logic r, input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                   input logic ov, input logic [31:0] pc, input logic se, input logic sm,
                   input logic fl, input logic ak, input exp_t e);
    @(negedge clk);
    rst = r; ex_wd = wd; ex_wreg = wreg; ex_wdata = wdata; ex_ov = ov; ex_pc = pc;
    stall_ex = se; stall_mem = sm; flush = fl; ack = ak;
    q.push_back(e);
  endtask
  initial begin
    v(0, 5'($urandom), 1, $urandom, 1, $urandom, 0, 0, 0, 0, '{0, 0, 0, 0, 0, 0, 0, 0});
    v(1, 3, 1, 32'h12345678, 0, 0, 0, 0, 0, 0, '{3, 1, 32'h12345678, 0, 0, 0, 0, 0});
    v(1, 5, 1, 32'h0000AAAA, 1, 32'h100, 1, 0, 0, 0, '{0, 0, 0, 0, 0, 0, 0, 0});
    v(1, 4, 1, 32'h0000CAFE, 0, 0, 0, 0, 0, 0, '{4, 1, 32'h0000CAFE, 0, 0, 0, 0, 0});
    v(1, 7, 0, 32'h0000BBBB, 0, 0, 1, 1, 0, 0, '{4, 1, 32'h0000CAFE, 0, 0, 0, 0, 0});
    v(1, 9, 1, 32'h00001111, 1, 32'h40, 0, 1, 1, 0, '{0, 0, 0, 0, 0, 0, 0, 0});
    v(1, 8, 0, 32'h7FFFFFFF, 1, 32'hBFC00010, 0, 0, 0, 0, '{8, 0, 32'h7FFFFFFF, 1, 32'hBFC00010, 8, 0, 1});
    v(1, 9, 0, 32'h00000001, 1, 32'h14, 0, 0, 0, 0, '{9, 0, 32'h1, 1, 32'hBFC00010, 8, 1, 2});
    v(1, 10, 1, 32'h80000000, 1, 32'h20, 0, 0, 0, 1, '{10, 1, 32'h80000000, 1, 32'h20, 10, 1, 3});
    v(1, 2, 1, 32'h00000005, 0, 0, 0, 0, 0, 1, '{2, 1, 32'h5, 0, 32'h20, 10, 1, 3});
    v(1, 0, 0, 32'h0, 0, 32'h24, 0, 0, 0, 1, '{0, 0, 0, 0, 32'h20, 10, 1, 3});
    v(1, 11, 0, 32'h0, 1, 32'h30, 0, 0, 0, 0, '{11, 0, 0, 1, 32'h30, 11, 1, 3});
    v(1, 12, 0, 32'h0, 1, 32'h34, 0, 0, 0, 0, '{12, 0, 0, 1, 32'h30, 11, 1, 3});
    @(negedge clk);
    #2;
    q.push_back('{0, 0, 0, 0, 0, 0, 0, 0});
    rst = 1'b0;
    v(0, 5'($urandom), 1, $urandom, 1, $urandom, 0, 0, 0, 1, '{0, 0, 0, 0, 0, 0, 0, 0});
    v(1, 1, 1, 32'h0000DEAD, 0, 0, 0, 0, 0, 0, '{1, 1, 32'h0000DEAD, 0, 0, 0, 0, 0});
    v(1, 6, 0, 32'h0, 1, 32'h44, 0, 0, 0, 0, '{6, 0, 0, 1, 32'h44, 6, 0, 1});
    repeat (4) @(posedge clk);
    #2;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/ex_mem_reg.md
Name: ex_mem_reg

Overview:
- EX→MEM pipeline boundary register.
- Captures the EX-stage writeback triple (dest address, write enable, result) and forwards it to the MEM stage.
- Implements stall bubbles and flush.
- Also the consuming end of the EX adder's overflow indication: latches an arithmetic-overflow exception record (PC, dest) and holds it until the exception unit acknowledges it, and keeps a saturating overflow count.

Parameters:
- DATA_W, 32, datapath / result width.
- ADDR_W, 5, register-file address width.
- CNT_W, 8, overflow event counter width.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- ex_wd_i  in  ADDR_W  EX destination register address.
- ex_wreg_i  in  1  EX write enable (already forced 0 by EX on signed overflow).
- ex_wdata_i  in  DATA_W  EX result.
- ex_ov_i  in  1  EX signed-overflow flag (ADD/SUB only); qualifies exception capture.
- ex_pc_i  in  DATA_W  PC of the instruction in EX.
- stall_ex_i  in  1  EX stage stalled this cycle.
- stall_mem_i  in  1  MEM stage stalled this cycle.
- flush_i  in  1  discard the EX instruction (exception/branch flush).
- exc_ack_i  in  1  exception unit has consumed the pending record.
- mem_wd_o  out  ADDR_W  registered destination address.
- mem_wreg_o  out  1  registered write enable.
- mem_wdata_o  out  DATA_W  registered result.
- exc_valid_o  out  1  overflow exception record pending.
- exc_epc_o  out  DATA_W  PC of the overflowing instruction.
- exc_wd_o  out  ADDR_W  destination of the suppressed write.
- exc_lost_o  out  1  sticky: an overflow arrived while a record was already pending.
- ov_count_o  out  CNT_W  saturating count of captured and lost overflows.

Behaviour:
- Reset (rst=0, async): every output 0; stays 0 while rst=0. Reset mid-operation drops any pending record without an ack.
- Latency: one cycle EX→MEM for all mem_* outputs.
- Update priority each rising edge, highest first:
  1. flush_i=1: mem_* <= 0 (bubble), regardless of stalls.
  2. stall_mem_i=1: mem_* hold.
  3. stall_ex_i=1 and stall_mem_i=0: mem_* <= 0 (bubble, so a stalled EX instruction is not duplicated).
  4. Otherwise: mem_* <= ex_*.
- Capture event: cap = ex_ov_i & ~flush_i & ~stall_ex_i. An overflow on a stalled or flushed instruction is never recorded.
- Exception record state machine, states IDLE and PEND (exc_valid_o = PEND):
  - IDLE & cap → PEND; load exc_epc_o <= ex_pc_i and exc_wd_o <= ex_wd_i.
  - PEND & exc_ack_i & ~cap → IDLE; record fields hold their last values.
  - PEND & exc_ack_i & cap → stay PEND; load the new record (back-to-back handoff, nothing lost).
  - PEND & ~exc_ack_i & cap → stay PEND; keep the old record; exc_lost_o <= 1.
  - exc_ack_i in IDLE is ignored.
- exc_lost_o is cleared only by reset.
- ov_count_o increments by 1 on every cap, saturates at 2^CNT_W−1, and never wraps.
- ex_ov_i with ex_wreg_i=1 is legal; the data path passes it through unchanged. The record is still captured.

Decomposition:
- Shared defines header gets: exception state encodings (EXC_IDLE, EXC_PEND), ZeroWord, and the NOPRegAddr constant used for bubbles.
- One sub-module is natural: sat_counter (parameter width; inputs inc and clear; output count). It is reusable for other perf counters.

Test Plan:
- Reset: rst=0 with random inputs → all outputs 0. Release reset, drive ex_wd=3, wreg=1, wdata=0x12345678 → mem_* equal these one cycle later.
- Stall: stall_ex=1, stall_mem=0 → mem_* = 0. Then stall_mem=1 with new ex inputs → mem_* hold their previous value.
- Flush priority: flush=1 together with stall_mem=1 and ex_ov=1 → mem_* = 0, exc_valid stays 0, ov_count unchanged.
- Overflow capture: ex_ov=1, pc=0xBFC00010, wd=8 → next cycle exc_valid=1, epc=0xBFC00010, wd_o=8, ov_count=1. Hold ack=0 and send a second overflow at pc=0x14 → epc stays 0xBFC00010, exc_lost=1, ov_count=2.
- Ack plus simultaneous capture: PEND, then exc_ack=1 with cap at pc=0x20 → exc_valid stays 1, epc=0x20. Next cycle ack=1 with no cap → exc_valid=0.
- Saturation: CNT_W=2, apply 5 overflows → ov_count=3. Assert rst=0 mid-PEND → exc_valid=0 and ov_count=0 immediately, without a clock edge.
